// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: defaults, output bundle and
// counter sizing shared by the button conditioning slice.
package button_conditioner_pkg;

   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 16;

   // Registered outputs of the debouncer, kept as one bundle
   typedef struct packed {
      logic level;
      logic press;
      logic rel;
      logic toggle;
   } btn_out_t;

   // Stability counter width; never narrower than one bit
   function automatic int cnt_width(input int cycles);
      int w;
      w = $clog2(cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: STAGES-deep flop chain for one async bit.
// Ports: clk, rst_n (async low), d (async in), q (synced out).
module bit_synchronizer #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= {STAGES{RST_VAL}};
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: sync + stability debounce + edge detect.
// Ports: clk, rst (async low), btn_in (raw, bouncy),
// btn_level, press_pulse, rel_pulse, en_toggle (all registered).
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int BTN_ACTIVE_HIGH = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic press_pulse,
   output logic rel_pulse,
   output logic en_toggle
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             raw;
   logic             s;
   logic             hold;
   logic             step;
   logic             accept;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   btn_out_t         out_q;
   btn_out_t         out_d;

   // Polarity is fixed before the synchronizer so the chain
   // always resets to "not pressed".
   assign raw = (BTN_ACTIVE_HIGH != 0) ? btn_in : ~btn_in;

   bit_synchronizer #(
      .STAGES (SYNC_STAGES),
      .RST_VAL(1'b0)
   ) u_sync (
      .clk  (clk),
      .rst_n(rst),
      .d    (raw),
      .q    (s)
   );

   // Exactly one of these holds every cycle
   assign hold   = (s == out_q.level);
   assign step   = !hold && (cnt_q < CNT_LAST);
   assign accept = !hold && (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d        = cnt_q;
      out_d        = out_q;
      out_d.press  = 1'b0;
      out_d.rel    = 1'b0;
      unique case (1'b1)
         hold: begin
            cnt_d = '0;
         end
         step: begin
            cnt_d = cnt_q + 1'b1;
         end
         accept: begin
            cnt_d        = '0;
            out_d.level  = s;
            out_d.press  = s;
            out_d.rel    = ~s;
            out_d.toggle = out_q.toggle ^ s;
         end
         default: begin
            cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         out_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         out_q <= out_d;
      end
   end

   assign btn_level   = out_q.level;
   assign press_pulse = out_q.press;
   assign rel_pulse   = out_q.rel;
   assign en_toggle   = out_q.toggle;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: vectors, corner sequences and random
// stimulus against a sliding-window reference model.
module tb_button_conditioner;

   localparam int SYNC = 2;
   localparam int DEB  = 4;

   typedef struct {
      logic       btn;
      int         hold;
      logic [3:0] exp;
      string      name;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn_in = 1'b0;
   logic btn_in_n;
   logic lvl, prs, rel, tog;
   logic lvl_n, prs_n, rel_n, tog_n;
   logic [3:0] outs, outs_n;

   int tests = 0;
   int fails = 0;

   assign btn_in_n = ~btn_in;
   assign outs     = {lvl, prs, rel, tog};
   assign outs_n   = {lvl_n, prs_n, rel_n, tog_n};

   always #5 clk = ~clk;

   button_conditioner #(
      .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
      .BTN_ACTIVE_HIGH(1)
   ) dut (
      .clk(clk), .rst(rst), .btn_in(btn_in),
      .btn_level(lvl), .press_pulse(prs),
      .rel_pulse(rel), .en_toggle(tog)
   );

   button_conditioner #(
      .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
      .BTN_ACTIVE_HIGH(0)
   ) dut_n (
      .clk(clk), .rst(rst), .btn_in(btn_in_n),
      .btn_level(lvl_n), .press_pulse(prs_n),
      .rel_pulse(rel_n), .en_toggle(tog_n)
   );

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a level is accepted when the last DEB
   // synchronized samples (raw delayed by SYNC edges, zero
   // before reset release) all differ from the current level.
   logic q_raw[$];
   logic m_lvl = 1'b0, m_prs = 1'b0, m_rel = 1'b0, m_tog = 1'b0;
   int   m_n;
   logic all_diff;

   function automatic logic s_at(input int j);
      if (j - SYNC < 1) return 1'b0;
      return q_raw[j-SYNC-1];
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_raw.delete();
         m_lvl = 1'b0; m_prs = 1'b0;
         m_rel = 1'b0; m_tog = 1'b0;
      end else begin
         q_raw.push_back(btn_in);
         m_n = q_raw.size();
         all_diff = 1'b1;
         for (int k = 0; k < DEB; k++) begin
            if (m_n - k < 1) all_diff = 1'b0;
            else if (s_at(m_n - k) == m_lvl) all_diff = 1'b0;
         end
         m_prs = all_diff && !m_lvl;
         m_rel = all_diff && m_lvl;
         if (all_diff) m_lvl = ~m_lvl;
         if (m_prs) m_tog = ~m_tog;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("model", outs, {m_lvl, m_prs, m_rel, m_tog});
         chk("model_n", outs_n, {m_lvl, m_prs, m_rel, m_tog});
      end
   end

   task automatic do_reset();
      btn_in = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   vec_t vecs[$];
   int   npr, nrel, ncoin, len;
   logic [2:0] togs;
   logic v;

   initial begin
      vecs.push_back('{1'b1, 5,  4'b0000, "press_wait"});
      vecs.push_back('{1'b1, 1,  4'b1101, "press_edge6"});
      vecs.push_back('{1'b1, 1,  4'b1001, "press_held"});
      vecs.push_back('{1'b0, 6,  4'b0011, "release_edge6"});
      vecs.push_back('{1'b0, 1,  4'b0001, "release_held"});
      vecs.push_back('{1'b1, 3,  4'b0001, "glitch3_on"});
      vecs.push_back('{1'b0, 10, 4'b0001, "glitch3_none"});
      vecs.push_back('{1'b1, 4,  4'b0001, "glitch4_on"});
      vecs.push_back('{1'b0, 2,  4'b1100, "glitch4_press"});
      vecs.push_back('{1'b0, 3,  4'b1000, "glitch4_wait"});
      vecs.push_back('{1'b0, 1,  4'b0010, "glitch4_rel"});
      vecs.push_back('{1'b0, 1,  4'b0000, "glitch4_idle"});

      // Reset held with the button pressed
      rst = 1'b0;
      btn_in = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_hold", outs, 4'b0000);
      chk("rst_hold_n", outs_n, 4'b0000);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("s1_edge5", outs, 4'b0000);
      @(negedge clk);
      chk("s1_edge6", outs, 4'b1101);
      chk("s1_edge6_n", outs_n, 4'b1101);
      @(negedge clk);
      chk("s1_edge7", outs, 4'b1001);
      btn_in = 1'b0;
      repeat (8) @(negedge clk);
      chk("s1_released", outs, 4'b0001);

      // Table-driven vectors from a fresh reset
      do_reset();
      foreach (vecs[i]) begin
         btn_in = vecs[i].btn;
         repeat (vecs[i].hold) @(negedge clk);
         chk(vecs[i].name, outs, vecs[i].exp);
      end

      // Bounce then steady press
      npr = 0;
      for (int i = 0; i < 10; i++) begin
         btn_in = (i % 2 == 0);
         @(negedge clk);
         if (prs) npr++;
      end
      btn_in = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (prs) npr++;
         chk($sformatf("bounce_e%0d", k), prs, (k == 6));
      end
      chk("bounce_count", npr, 1);
      btn_in = 1'b0;
      repeat (8) @(negedge clk);

      // Three press/release cycles
      do_reset();
      nrel = 0;
      ncoin = 0;
      for (int c = 0; c < 3; c++) begin
         btn_in = 1'b1;
         repeat (8) begin
            @(negedge clk);
            if (rel) nrel++;
            if (prs && rel) ncoin++;
         end
         togs[c] = tog;
         btn_in = 1'b0;
         repeat (8) begin
            @(negedge clk);
            if (rel) nrel++;
            if (prs && rel) ncoin++;
         end
      end
      chk("toggle_seq", togs, 3'b101);
      chk("rel_count", nrel, 3);
      chk("no_coincide", ncoin, 0);

      // Async reset in the middle of a qualification
      btn_in = 1'b1;
      repeat (7) @(negedge clk);
      btn_in = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_rst", outs, 4'b1000);
      #2 rst = 1'b0;
      #1;
      chk("async_rst", outs, 4'b0000);
      chk("async_rst_n", outs_n, 4'b0000);
      @(negedge clk);
      btn_in = 1'b1;
      rst = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk($sformatf("requal_e%0d", k), outs,
             (k == 6) ? 4'b1101 : 4'b0000);
      end

      // Random runs with occasional async resets
      do_reset();
      v = 1'b0;
      for (int r = 0; r < 400; r++) begin
         v = ~v;
         len = $urandom_range(1, 9);
         btn_in = v;
         repeat (len) @(negedge clk);
         if ($urandom_range(0, 40) == 0) begin
            #3 rst = 1'b0;
            #1;
            chk("rand_rst", outs, 4'b0000);
            @(negedge clk);
            rst = 1'b1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
